// File: rtl/wa_arb_mon.sv
// rtl/wa_arb_mon.sv - N-channel write-address arbitration rule monitor (optional starvation check: WA_ARB_MON_STARVE_EN)
module wa_arb_mon #(
    parameter int NCH        = 3,
    parameter int WW         = 16,
    parameter int CW         = 17,
    parameter int ECW        = 16,
    parameter int STARVE_MAX = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    arb_en,
    input  logic [1:0]              arb_mode,
    input  logic [NCH*WW-1:0]       weight,
    input  logic [NCH-1:0]          wavalid,
    input  logic [NCH-1:0]          waready,
    input  logic [NCH-1:0]          wasuc,
    input  logic                    clr_err,
    output logic [7:0]              err_vec,
    output logic [ECW-1:0]          err_cnt,
    output logic [2:0]              first_err_code,
    output logic [$clog2(NCH)-1:0]  first_err_ch,
    output logic [NCH-1:0]          starve_ch
);
    localparam int CHW = $clog2(NCH);

    logic [CW-1:0]       r_run [NCH];
    logic [NCH-1:0]      r_vld_d;
    logic [7:0]          r_err_vec;
    logic [ECW-1:0]      r_err_cnt;
    logic [2:0]          r_first_code;
    logic [CHW-1:0]      r_first_ch;
    logic [NCH-1:0]      r_starve;

    logic [7:0][NCH-1:0] w_rule_ch;
    logic [7:0]          w_hits;
    logic                w_any_hit;
    logic [2:0]          w_code;
    logic [CHW-1:0]      w_ch;
    logic [NCH-1:0]      w_starve_hit;
    logic [ECW-1:0]      w_cnt_base;

    function automatic logic [CHW-1:0] lowest_set(input logic [NCH-1:0] v);
        lowest_set = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (v[c]) lowest_set = CHW'(c);
        end
    endfunction

`ifdef WA_ARB_MON_STARVE_EN
    localparam int WTW = $clog2(STARVE_MAX + 1);

    logic [WTW-1:0] r_wait     [NCH];
    logic [WTW-1:0] w_wait_nxt [NCH];

    // Next waiting time per channel; a channel is starving once it reaches STARVE_MAX
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            if (wasuc[i] || !wavalid[i])
                w_wait_nxt[i] = '0;
            else if (arb_en && r_wait[i] != WTW'(STARVE_MAX))
                w_wait_nxt[i] = r_wait[i] + WTW'(1);
            else
                w_wait_nxt[i] = r_wait[i];
            w_starve_hit[i] = (w_wait_nxt[i] == WTW'(STARVE_MAX));
        end
    end

    // Waiting-time registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) r_wait[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) r_wait[i] <= w_wait_nxt[i];
        end
    end
`else
    assign w_starve_hit = '0;
`endif

    // Per-rule offending-channel vectors from current strobes and registered state
    always_comb begin
        logic [NCH-1:0] v_lower;
        logic [CW-1:0]  v_quota;
        logic           v_pend;
        w_rule_ch = '0;
        v_lower   = '0;
        for (int i = 0; i < NCH; i++) begin
            v_quota = (weight[i*WW +: WW] == '0) ? CW'(1) : CW'(weight[i*WW +: WW]);
            v_pend  = |(r_vld_d & ~(NCH'(1) << i));
            w_rule_ch[0][i] = ($countones(wasuc) > 1) && wasuc[i];
            w_rule_ch[1][i] = wasuc[i] && !(wavalid[i] && waready[i]);
            w_rule_ch[2][i] = !arb_en && wasuc[i] && (i != 0);
            w_rule_ch[3][i] = arb_en && (arb_mode == 2'd0) && wasuc[i] && (|v_lower);
            w_rule_ch[4][i] = arb_en && (arb_mode == 2'd1) && wasuc[i] && (r_run[i] != '0) && v_pend;
            w_rule_ch[5][i] = arb_en && (arb_mode == 2'd2) && wasuc[i] && (r_run[i] >= v_quota) && v_pend;
            w_rule_ch[6][i] = arb_en && (arb_mode == 2'd3) && wasuc[i];
            v_lower[i] = wavalid[i];
        end
        w_rule_ch[7] = w_starve_hit;
    end

    // Collapse rule vectors and pick the lowest rule / lowest channel for first-error capture
    always_comb begin
        w_code = '0;
        w_ch   = '0;
        for (int r = 0; r < 8; r++) w_hits[r] = |w_rule_ch[r];
        for (int r = 7; r >= 0; r--) begin
            if (w_hits[r]) begin
                w_code = 3'(r);
                w_ch   = lowest_set(w_rule_ch[r]);
            end
        end
    end

    assign w_any_hit  = |w_hits;
    assign w_cnt_base = clr_err ? '0 : r_err_cnt;

    // Consecutive-grant run length per channel; any grant elsewhere restarts it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) r_run[i] <= '0;
            r_vld_d <= '0;
        end else begin
            r_vld_d <= wavalid;
            for (int i = 0; i < NCH; i++) begin
                if (wasuc[i] && arb_en) begin
                    if (r_run[i] != '1) r_run[i] <= r_run[i] + CW'(1);
                end else if (|(wasuc & ~(NCH'(1) << i))) begin
                    r_run[i] <= '0;
                end
            end
        end
    end

    // Sticky flags, saturating hit-cycle counter and first-error capture; clear acts before new hits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_vec    <= '0;
            r_err_cnt    <= '0;
            r_first_code <= '0;
            r_first_ch   <= '0;
            r_starve     <= '0;
        end else begin
            r_err_vec <= (clr_err ? 8'h00 : r_err_vec) | w_hits;
            r_err_cnt <= (w_any_hit && w_cnt_base != '1) ? w_cnt_base + ECW'(1) : w_cnt_base;
            r_starve  <= (clr_err ? '0 : r_starve) | w_starve_hit;
            if (w_any_hit && (r_err_vec == 8'h00 || clr_err)) begin
                r_first_code <= w_code;
                r_first_ch   <= w_ch;
            end else if (clr_err) begin
                r_first_code <= '0;
                r_first_ch   <= '0;
            end
        end
    end

    assign err_vec        = r_err_vec;
    assign err_cnt        = r_err_cnt;
    assign first_err_code = r_first_code;
    assign first_err_ch   = r_first_ch;
    assign starve_ch      = r_starve;

endmodule

// File: tb/tb_wa_arb_mon.sv
// tb/tb_wa_arb_mon.sv - self-checking bench for wa_arb_mon with behavioural rule model
module tb_wa_arb_mon;
    localparam int NCH     = 3;
    localparam int WW      = 4;
    localparam int CW      = 5;
    localparam int ECW     = 4;
    localparam int SM      = 4;
    localparam int RUN_MAX = (1 << CW) - 1;
    localparam int CNT_MAX = (1 << ECW) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              arb_en;
    logic [1:0]        arb_mode;
    logic [WW-1:0]     wt [NCH];
    logic [NCH*WW-1:0] weight;
    logic [NCH-1:0]    wavalid, waready, wasuc;
    logic              clr_err;
    logic [7:0]        err_vec;
    logic [ECW-1:0]    err_cnt;
    logic [2:0]        first_err_code;
    logic [1:0]        first_err_ch;
    logic [NCH-1:0]    starve_ch;

    always #5 clk = ~clk;
    assign weight = {wt[2], wt[1], wt[0]};

    wa_arb_mon #(.NCH(NCH), .WW(WW), .CW(CW), .ECW(ECW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst), .arb_en(arb_en), .arb_mode(arb_mode), .weight(weight),
        .wavalid(wavalid), .waready(waready), .wasuc(wasuc), .clr_err(clr_err),
        .err_vec(err_vec), .err_cnt(err_cnt), .first_err_code(first_err_code),
        .first_err_ch(first_err_ch), .starve_ch(starve_ch)
    );

    int             m_run  [NCH];
    int             m_wait [NCH];
    logic [NCH-1:0] m_vldd, m_starve;
    logic [7:0]     m_vec;
    int             m_cnt, m_code, m_ch;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_run[i]  = 0;
            m_wait[i] = 0;
        end
        m_vldd = '0; m_starve = '0; m_vec = '0;
        m_cnt = 0; m_code = 0; m_ch = 0;
    endtask

    task automatic model_step();
        int   first [8];
        bit   cond  [8];
        int   nw    [NCH];
        int   nsuc, quota, ncode, nch;
        bit   pend, lower, anyhit;
        logic [7:0]     hv;
        logic [NCH-1:0] svec;
        if (rst) begin
            model_reset();
        end else begin
            for (int r = 0; r < 8; r++) first[r] = -1;
            svec = '0;
            nsuc = $countones(wasuc);
            for (int i = 0; i < NCH; i++) begin
                pend = 0; lower = 0;
                for (int j = 0; j < NCH; j++) begin
                    if (j != i && m_vldd[j]) pend = 1;
                    if (j < i && wavalid[j]) lower = 1;
                end
                quota = (wt[i] == 0) ? 1 : int'(wt[i]);
                cond[0] = nsuc > 1 && wasuc[i];
                cond[1] = wasuc[i] && !(wavalid[i] && waready[i]);
                cond[2] = !arb_en && wasuc[i] && i != 0;
                cond[3] = arb_en && arb_mode == 0 && wasuc[i] && lower;
                cond[4] = arb_en && arb_mode == 1 && wasuc[i] && m_run[i] >= 1 && pend;
                cond[5] = arb_en && arb_mode == 2 && wasuc[i] && m_run[i] >= quota && pend;
                cond[6] = arb_en && arb_mode == 3 && wasuc[i];
`ifdef WA_ARB_MON_STARVE_EN
                if (wasuc[i] || !wavalid[i]) nw[i] = 0;
                else if (arb_en) nw[i] = (m_wait[i] + 1 > SM) ? SM : m_wait[i] + 1;
                else nw[i] = m_wait[i];
                cond[7] = (nw[i] == SM);
`else
                nw[i] = 0;
                cond[7] = 0;
`endif
                svec[i] = cond[7];
                for (int r = 0; r < 8; r++) if (cond[r] && first[r] < 0) first[r] = i;
            end
            for (int r = 0; r < 8; r++) hv[r] = (first[r] >= 0);
            anyhit = |hv;
            ncode = 0; nch = 0;
            for (int r = 7; r >= 0; r--) if (hv[r]) begin ncode = r; nch = first[r]; end
            if (anyhit && (m_vec == 0 || clr_err)) begin
                m_code = ncode; m_ch = nch;
            end else if (clr_err) begin
                m_code = 0; m_ch = 0;
            end
            m_vec    = (clr_err ? 8'h00 : m_vec) | hv;
            m_cnt    = (clr_err ? 0 : m_cnt) + (anyhit ? 1 : 0);
            if (m_cnt > CNT_MAX) m_cnt = CNT_MAX;
            m_starve = (clr_err ? '0 : m_starve) | svec;
            for (int i = 0; i < NCH; i++) begin
                if (wasuc[i] && arb_en) m_run[i] = (m_run[i] < RUN_MAX) ? m_run[i] + 1 : RUN_MAX;
                else if ((wasuc & ~(NCH'(1) << i)) != 0) m_run[i] = 0;
                m_wait[i] = nw[i];
            end
            m_vldd = wavalid;
        end
    endtask

    task automatic cyc(input bit en, input logic [1:0] md, input logic [NCH-1:0] v,
                       input logic [NCH-1:0] r, input logic [NCH-1:0] s, input bit c);
        arb_en = en; arb_mode = md; wavalid = v; waready = r; wasuc = s; clr_err = c;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clr_cyc();
        cyc(1'b1, 2'd0, 3'b000, 3'b000, 3'b000, 1'b1);
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("err_vec", int'(err_vec), int'(m_vec));
            chk("err_cnt", int'(err_cnt), m_cnt);
            chk("first_err_code", int'(first_err_code), m_code);
            chk("first_err_ch", int'(first_err_ch), m_ch);
            chk("starve_ch", int'(starve_ch), int'(m_starve));
        end
    end

    initial begin
        logic [NCH-1:0] v, r, s;
        logic [1:0]     md;
        bit             en, c;
        int             k;
        arb_en = 0; arb_mode = 0; wavalid = 0; waready = 0; wasuc = 0; clr_err = 0;
        for (int i = 0; i < NCH; i++) wt[i] = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_vec", int'(err_vec), 0);
        chk("reset_cnt", int'(err_cnt), 0);
        chk("reset_code", int'(first_err_code), 0);
        chk("reset_ch", int'(first_err_ch), 0);
        chk("reset_starve", int'(starve_ch), 0);
        cmp_on = 1'b1;

        // fixed priority: lower channel pending while ch1 granted
        cyc(1, 2'd0, 3'b011, 3'b111, 3'b010, 0);
        chk("m0_vec", int'(err_vec), 8'h08);
        chk("m0_cnt", int'(err_cnt), 1);
        chk("m0_code", int'(first_err_code), 3);
        chk("m0_ch", int'(first_err_ch), 1);
        clr_cyc();
        chk("clr_code", int'(first_err_code), 0);
        chk("clr_ch", int'(first_err_ch), 0);
        chk("clr_cnt", int'(err_cnt), 0);

        // round-robin: repeat grant to ch0 with ch1 pending
        cyc(1, 2'd1, 3'b011, 3'b111, 3'b001, 0);
        chk("m1_first_ok", int'(err_vec), 0);
        cyc(1, 2'd1, 3'b011, 3'b111, 3'b001, 0);
        chk("m1_vec", int'(err_vec), 8'h10);
        clr_cyc();
        cyc(1, 2'd1, 3'b111, 3'b111, 3'b001, 0);
        cyc(1, 2'd1, 3'b111, 3'b111, 3'b010, 0);
        cyc(1, 2'd1, 3'b111, 3'b111, 3'b100, 0);
        cyc(1, 2'd1, 3'b111, 3'b111, 3'b001, 0);
        chk("m1_rotate_vec", int'(err_vec), 0);

        // weighted: ch0 weight 2, third consecutive grant is the violation
        wt[0] = 4'd2; wt[1] = 4'd3; wt[2] = 4'd1;
        clr_cyc();
        cyc(1, 2'd2, 3'b010, 3'b010, 3'b010, 0);
        cyc(1, 2'd2, 3'b101, 3'b111, 3'b001, 0);
        cyc(1, 2'd2, 3'b101, 3'b111, 3'b001, 0);
        chk("m2_cnt_before", int'(err_cnt), 0);
        cyc(1, 2'd2, 3'b101, 3'b111, 3'b001, 0);
        chk("m2_cnt", int'(err_cnt), 1);
        chk("m2_vec", int'(err_vec), 8'h20);
        chk("m2_code", int'(first_err_code), 5);
        clr_cyc();

        // arbiter disabled grant to ch2, then multi-grant with concurrent clear
        cyc(0, 2'd1, 3'b100, 3'b100, 3'b100, 0);
        chk("dis_vec", int'(err_vec), 8'h04);
        chk("dis_ch", int'(first_err_ch), 2);
        cyc(1, 2'd1, 3'b011, 3'b011, 3'b011, 1);
        chk("clrhit_vec", int'(err_vec), 8'h01);
        chk("clrhit_cnt", int'(err_cnt), 1);
        chk("clrhit_code", int'(first_err_code), 0);
        clr_cyc();

        // starvation: ch2 requests four cycles without a grant
        repeat (3) cyc(1, 2'd0, 3'b100, 3'b000, 3'b000, 0);
        chk("starve_early", int'(starve_ch), 0);
        cyc(1, 2'd0, 3'b100, 3'b000, 3'b000, 0);
`ifdef WA_ARB_MON_STARVE_EN
        chk("starve_ch", int'(starve_ch), 3'b100);
        chk("starve_vec7", int'(err_vec[7]), 1);
`else
        chk("starve_ch", int'(starve_ch), 0);
        chk("starve_vec7", int'(err_vec[7]), 0);
`endif
        clr_cyc();

        // asynchronous reset mid-burst, then counter saturation
        repeat (5) cyc(1, 2'd1, 3'b011, 3'b011, 3'b011, 0);
        chk("burst_cnt", int'(err_cnt), 5);
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_vec", int'(err_vec), 0);
        chk("arst_cnt", int'(err_cnt), 0);
        chk("arst_code", int'(first_err_code), 0);
        chk("arst_ch", int'(first_err_ch), 0);
        chk("arst_starve", int'(starve_ch), 0);
        cyc(1, 2'd1, 3'b011, 3'b011, 3'b011, 0);
        rst = 1'b0;
        repeat (CNT_MAX + 4) cyc(1, 2'd1, 3'b011, 3'b011, 3'b011, 0);
        chk("sat_cnt", int'(err_cnt), CNT_MAX);
        clr_cyc();

        // randomized traffic against the model
        md = 2'd0;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 49) == 0) md = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) wt[$urandom_range(0, NCH - 1)] = 4'($urandom_range(0, 3));
            en = ($urandom_range(0, 7) != 0);
            v  = NCH'($urandom);
            r  = NCH'($urandom);
            k  = $urandom_range(0, 9);
            if (k < 6) begin
                k = $urandom_range(0, NCH - 1);
                s = (v[k] && r[k]) ? (NCH'(1) << k) : '0;
            end else if (k < 8) begin
                s = '0;
            end else begin
                s = NCH'($urandom);
            end
            c = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 299) == 0);
            if (rst) model_reset();
            cyc(en, md, v, r, s, c);
        end
        rst = 1'b0;
        cyc(1, 2'd0, 3'b000, 3'b000, 3'b000, 0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wa_arb_mon.md
# wa_arb_mon

Parametrised N-channel write-address arbitration monitor. Sits beside the write-address arbiter in the environment, samples per-channel request and grant-success strobes, and checks that grants obey the selected arbitration mode (fixed priority, round-robin, weighted round-robin). Violations are reported as registered sticky flags, a saturating error counter and a first-error capture, so both the scoreboard and waveform debug can consume them.

## Interface
- NCH, 3, number of arbitrated channels (2..16)
- WW, 16, per-channel weight width
- CW, 17, run-counter width (must exceed WW)
- ECW, 16, error-counter width
- STARVE_MAX, 64, wait cycles before a starvation error (STARVE_MAX >= 1)
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- arb_en  in  1  arbiter enable; when low only channel 0 may be granted
- arb_mode  in  2  0 fixed priority, 1 round-robin, 2 weighted, 3 reserved
- weight  in  NCH*WW  channel i weight at [i*WW +: WW]; 0 treated as 1
- wavalid  in  NCH  per-channel request
- waready  in  NCH  per-channel ready
- wasuc  in  NCH  per-channel grant-success strobe
- clr_err  in  1  synchronous clear of all error state
- err_vec  out  8  sticky per-rule flags, bit n = rule Rn
- err_cnt  out  ECW  count of cycles with at least one hit, saturating
- first_err_code  out  3  lowest rule index of the first hit cycle
- first_err_ch  out  $clog2(NCH)  lowest offending channel of that rule
- starve_ch  out  NCH  sticky per-channel starvation flags

## Operation
- State per channel: run[i] (CW bits), vld_d[i] (wavalid delayed one cycle), wait[i].
- run[i]: wasuc[i]&&arb_en -> run[i]+1, saturating at all-ones; else any wasuc[j], j!=i -> 0; else hold. Mode changes do not clear run.
- pend_other(i) = |(vld_d & ~(1<<i)).
- Rules, evaluated on current inputs plus registered state:
  - R0: more than one wasuc bit set.
  - R1: wasuc[i] && !(wavalid[i] && waready[i]).
  - R2: !arb_en && wasuc[i], i != 0.
  - R3: arb_en, mode 0, wasuc[i] && wavalid[j], j < i.
  - R4: arb_en, mode 1, wasuc[i] && run[i] >= 1 && pend_other(i).
  - R5: arb_en, mode 2, wasuc[i] && run[i] >= max(weight[i],1) && pend_other(i).
  - R6: arb_en, mode 3, any wasuc bit set.
  - R7: starvation (see Configuration).
- hits = 8-bit rule vector. Each clock edge: err_vec <= (clr_err ? 0 : err_vec) | hits. err_cnt <= (clr_err ? 0 : err_cnt) + (|hits), saturating.
- first_err_*: loaded when |hits and (err_vec == 0 or clr_err); otherwise held. clr_err with no hits zeroes them.
- Weight compare is unsigned; weight zero-extended to CW.

## Timing
- All outputs registered; a violation at edge k is visible after edge k (same-cycle sampling, one-register latency).
- Reset: run, vld_d, wait, err_vec, err_cnt, first_err_code, first_err_ch, starve_ch all 0; takes effect asynchronously, mid-operation state is discarded.
- clr_err concurrent with a hit: clear applies first, the new hit is recorded (err_cnt = 1).
- err_cnt holds at 2^ECW-1 once reached.
- First cycle after reset: vld_d = 0, so R4/R5 cannot fire.

## Configuration
- WA_ARB_MON_STARVE_EN defined: wait[i] ($clog2(STARVE_MAX+1) bits) increments, saturating, when arb_en && wavalid[i] && !wasuc[i]; clears when wasuc[i] or !wavalid[i]. When wait[i] reaches STARVE_MAX, R7 fires and starve_ch[i] sets; starve_ch clears only on rst or clr_err.
- Not defined: no wait counters, R7 and err_vec[7] tied 0, starve_ch tied 0.

## Test plan
- Mode 0, wavalid=3'b011, wasuc=3'b010 one cycle -> err_vec[3]=1, err_cnt=1, first_err_code=3, first_err_ch=1.
- Mode 1, channel 0 granted twice in a row while wavalid[1]=1 the cycle before -> err_vec[4]=1; alternate 0,1,2 grants -> err_vec stays 0.
- Mode 2, weight0=2, ch0 granted three consecutive cycles with ch2 pending -> hit only on third grant (run0=2), err_cnt=1.
- arb_en=0, wasuc=3'b100 -> err_vec[2]=1; wasuc=3'b011 same cycle as clr_err -> err_vec=8'h01, err_cnt=1, first_err_code=0.
- Macro on, STARVE_MAX=4, wavalid[2]=1 held 4 cycles ungranted -> starve_ch=3'b100, err_vec[7]=1; macro off -> both stay 0.
- Assert rst mid-burst with err_cnt=5 -> all outputs 0 immediately; 2^ECW+3 violating cycles -> err_cnt saturates at all-ones.
